// File: rtl/algorithm_reduce_if.sv
// Handshake bundle for algorithm_reduce: start request, element stream and result.
// The master side drives start/stream/result-accept; the slave side is the reducer.
interface algorithm_reduce_if #(
    parameter int N     = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       mode;
    logic [N-1:0]     sIn;
    logic             sIn_valid;
    logic             sIn_end;
    logic             sIn_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             ovf;

    modport master (
        output in_valid, mode, sIn, sIn_valid, sIn_end, out_ready,
        input  in_ready, sIn_ready, out_valid, sum, count, ovf
    );

    modport slave (
        input  in_valid, mode, sIn, sIn_valid, sIn_end, out_ready,
        output in_ready, sIn_ready, out_valid, sum, count, ovf
    );
endinterface

// File: rtl/algorithm_reduce.sv
// Stream reduction unit: folds signed N-bit elements into an ACC_W-bit result with a
// run-time selected operator, counts data beats and flags signed overflow/saturation.
module algorithm_reduce #(
    parameter int N     = 8,
    parameter int ACC_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    algorithm_reduce_if.slave    bus,
    output logic [1:0]           state_o
);
    // All handshakes are valid/ready: a transfer happens on a rising edge where both are
    // high. Start (in_valid/in_ready) is taken only in IDLE, stream beats only in RUN and
    // the result (out_valid/out_ready) only in DONE; valids seen in other states are dropped.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_WRAP  = 3'd0;
    localparam logic [2:0] M_SAT   = 3'd1;
    localparam logic [2:0] M_MIN   = 3'd2;
    localparam logic [2:0] M_MAX   = 3'd3;
    localparam logic [2:0] M_AND   = 3'd4;
    localparam logic [2:0] M_OR    = 3'd5;
    localparam logic [2:0] M_XOR   = 3'd6;
    localparam logic [2:0] M_COUNT = 3'd7;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic [2:0]              mode_q, mode_d;

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] add_res;
    logic                    add_ovf;

    assign x_ext   = ACC_W'(signed'(bus.sIn));
    assign add_res = acc_q + x_ext;
    // Signed overflow: operands share a sign and the sum's sign differs from it.
    assign add_ovf = (acc_q[ACC_W-1] == x_ext[ACC_W-1]) && (add_res[ACC_W-1] != acc_q[ACC_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= M_WRAP;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mode_d  = bus.mode;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                    case (bus.mode)
                        M_MIN:   acc_d = ACC_MAX;
                        M_MAX:   acc_d = ACC_MIN;
                        M_AND:   acc_d = '1;
                        default: acc_d = '0;
                    endcase
                end
            end
            S_RUN: begin
                if (bus.sIn_valid) begin
                    if (bus.sIn_end) begin
                        state_d = S_DONE;
                    end else begin
                        if (count_q != '1) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        case (mode_q)
                            M_WRAP: begin
                                acc_d = add_res;
                                if (add_ovf) ovf_d = 1'b1;
                            end
                            M_SAT: begin
                                if (add_ovf) begin
                                    acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                                    ovf_d = 1'b1;
                                end else begin
                                    acc_d = add_res;
                                end
                            end
                            M_MIN:   if (x_ext < acc_q) acc_d = x_ext;
                            M_MAX:   if (x_ext > acc_q) acc_d = x_ext;
                            M_AND:   acc_d = acc_q & x_ext;
                            M_OR:    acc_d = acc_q | x_ext;
                            M_XOR:   acc_d = acc_q ^ x_ext;
                            default: acc_d = acc_q;
                        endcase
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Count mode reports the beat counter instead of the (untouched) accumulator.
    assign bus.sum       = (mode_q == M_COUNT) ? ACC_W'(count_q) : acc_q;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.sIn_ready = (state_q == S_RUN);
    assign bus.out_valid = (state_q == S_DONE);
    assign state_o       = state_q;
endmodule

// File: tb/tb_algorithm_reduce.sv
// Bench for algorithm_reduce: a 16-bit and an 8-bit accumulator instance run in lockstep
// from one stimulus, checked against a table of known vectors and an arithmetic model.
module tb_algorithm_reduce;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, s_in_valid, s_in_end, out_ready;
    logic [2:0] mode;
    logic [7:0] s_in;
    logic [1:0] st16, st8;

    int checks   = 0;
    int failures = 0;

    logic [7:0] stim_q[$];

    typedef struct {
        logic [2:0]      m;
        int              len;
        logic [3:0][7:0] d;
        longint          e16;
        longint          e8;
        longint          ecnt;
        bit              eo16;
        bit              eo8;
    } vec_t;

    vec_t vt[13];

    algorithm_reduce_if #(.N(8), .ACC_W(16), .CNT_W(16)) bus16 ();
    algorithm_reduce_if #(.N(8), .ACC_W(8),  .CNT_W(16)) bus8 ();

    algorithm_reduce #(.N(8), .ACC_W(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16), .state_o(st16));
    algorithm_reduce #(.N(8), .ACC_W(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .state_o(st8));

    assign bus16.in_valid  = in_valid;
    assign bus16.mode      = mode;
    assign bus16.sIn       = s_in;
    assign bus16.sIn_valid = s_in_valid;
    assign bus16.sIn_end   = s_in_end;
    assign bus16.out_ready = out_ready;
    assign bus8.in_valid   = in_valid;
    assign bus8.mode       = mode;
    assign bus8.sIn        = s_in;
    assign bus8.sIn_valid  = s_in_valid;
    assign bus8.sIn_end    = s_in_end;
    assign bus8.out_ready  = out_ready;

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] m, input int len, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                                input longint e16, input longint e8, input longint ecnt,
                                input bit eo16, input bit eo8);
        vec_t v;
        v.m = m; v.len = len; v.d = {d3, d2, d1, d0};
        v.e16 = e16; v.e8 = e8; v.ecnt = ecnt; v.eo16 = eo16; v.eo8 = eo8;
        return v;
    endfunction

    // Reference: fold the queued elements with mathematical integers, width w.
    function automatic void model(input int m, input int w, output longint res, output bit ov);
        longint maxv, minv, span, a, x, t;
        maxv = (longint'(1) <<< (w - 1)) - 1;
        minv = -maxv - 1;
        span = longint'(1) <<< w;
        ov = 0;
        case (m)
            2:       a = maxv;
            3:       a = minv;
            4:       a = -1;
            default: a = 0;
        endcase
        foreach (stim_q[i]) begin
            x = longint'($signed(stim_q[i]));
            case (m)
                0: begin
                    t = a + x;
                    if (t > maxv) begin ov = 1; t = t - span; end
                    else if (t < minv) begin ov = 1; t = t + span; end
                    a = t;
                end
                1: begin
                    t = a + x;
                    if (t > maxv) begin ov = 1; t = maxv; end
                    else if (t < minv) begin ov = 1; t = minv; end
                    a = t;
                end
                2: if (x < a) a = x;
                3: if (x > a) a = x;
                4: a = a & x;
                5: a = a | x;
                6: a = a ^ x;
                default: a = a;
            endcase
        end
        if (m == 7) a = longint'(stim_q.size());
        res = a & (span - 1);
    endfunction

    // ---------------- driver ----------------
    task automatic run_txn(input logic [2:0] m, input longint e16, input longint e8,
                           input longint ecnt, input bit eo16, input bit eo8,
                           input int max_gap, input int hold, input string tag);
        int t = 0;
        while (!bus16.in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, " in_ready before start"}, longint'(bus16.in_ready), 1);
        in_valid = 1'b1;
        mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode = 3'($urandom_range(0, 7));
        chk({tag, " sIn_ready after start"}, longint'(bus16.sIn_ready), 1);
        chk({tag, " in_ready after start"}, longint'(bus16.in_ready), 0);
        foreach (stim_q[i]) begin
            repeat ($urandom_range(0, max_gap)) begin
                s_in_valid = 1'b0;
                s_in = 8'($urandom_range(0, 255));
                in_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk({tag, " count during gap"}, longint'(bus16.count), longint'(i));
            end
            s_in_valid = 1'b1;
            s_in_end = 1'b0;
            s_in = stim_q[i];
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        s_in_valid = 1'b1;
        s_in_end = 1'b1;
        s_in = 8'($urandom_range(0, 255));
        in_valid = 1'b0;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_in_end = 1'b0;
        chk({tag, " out_valid after end"}, longint'(bus16.out_valid), 1);
        chk({tag, " sIn_ready in done"}, longint'(bus16.sIn_ready), 0);
        chk({tag, " sum16"}, longint'(bus16.sum), e16);
        chk({tag, " sum8"}, longint'(bus8.sum), e8);
        chk({tag, " count"}, longint'(bus16.count), ecnt);
        chk({tag, " ovf16"}, longint'(bus16.ovf), longint'(eo16));
        chk({tag, " ovf8"}, longint'(bus8.ovf), longint'(eo8));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " held out_valid"}, longint'(bus16.out_valid), 1);
            chk({tag, " held sum16"}, longint'(bus16.sum), e16);
            chk({tag, " held count"}, longint'(bus8.count), ecnt);
            chk({tag, " held ovf8"}, longint'(bus8.ovf), longint'(eo8));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " in_ready after result"}, longint'(bus16.in_ready), 1);
        chk({tag, " out_valid after result"}, longint'(bus16.out_valid), 0);
    endtask

    task automatic load_vec(input vec_t v);
        stim_q.delete();
        for (int k = 0; k < v.len; k++) stim_q.push_back(v.d[k]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0; mode = 3'd0; s_in = 8'd0;
        s_in_valid = 1'b0; s_in_end = 1'b0; out_ready = 1'b0;

        vt[0]  = mk(3'd0, 4, 8'h01, 8'h02, 8'h03, 8'hff, 64'h0005, 64'h05, 4, 0, 0);
        vt[1]  = mk(3'd0, 2, 8'h7f, 8'h7f, 8'h00, 8'h00, 64'h00fe, 64'hfe, 2, 0, 1);
        vt[2]  = mk(3'd1, 2, 8'h7f, 8'h7f, 8'h00, 8'h00, 64'h00fe, 64'h7f, 2, 0, 1);
        vt[3]  = mk(3'd2, 3, 8'h05, 8'h80, 8'h7f, 8'h00, 64'hff80, 64'h80, 3, 0, 0);
        vt[4]  = mk(3'd3, 3, 8'h05, 8'h80, 8'h7f, 8'h00, 64'h007f, 64'h7f, 3, 0, 0);
        vt[5]  = mk(3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 64'h0000, 64'h00, 0, 0, 0);
        vt[6]  = mk(3'd2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 64'h7fff, 64'h7f, 0, 0, 0);
        vt[7]  = mk(3'd4, 0, 8'h00, 8'h00, 8'h00, 8'h00, 64'hffff, 64'hff, 0, 0, 0);
        vt[8]  = mk(3'd4, 2, 8'hf0, 8'h3c, 8'h00, 8'h00, 64'h0030, 64'h30, 2, 0, 0);
        vt[9]  = mk(3'd5, 2, 8'h01, 8'h80, 8'h00, 8'h00, 64'hff81, 64'h81, 2, 0, 0);
        vt[10] = mk(3'd6, 3, 8'h0f, 8'hff, 8'h01, 8'h00, 64'hfff1, 64'hf1, 3, 0, 0);
        vt[11] = mk(3'd7, 3, 8'h01, 8'h02, 8'h03, 8'h00, 64'h0003, 64'h03, 3, 0, 0);
        vt[12] = mk(3'd1, 3, 8'h80, 8'h80, 8'h80, 8'h00, 64'hfe80, 64'h80, 3, 0, 1);

        #12;
        chk("reset in_ready", longint'(bus16.in_ready), 1);
        chk("reset sIn_ready", longint'(bus16.sIn_ready), 0);
        chk("reset out_valid", longint'(bus16.out_valid), 0);
        chk("reset sum", longint'(bus16.sum), 0);
        chk("reset count", longint'(bus16.count), 0);
        chk("reset ovf", longint'(bus8.ovf), 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Known vectors, no stalls, back to back.
        for (int v = 0; v < 13; v++) begin
            load_vec(vt[v]);
            run_txn(vt[v].m, vt[v].e16, vt[v].e8, vt[v].ecnt, vt[v].eo16, vt[v].eo8,
                    0, 0, $sformatf("vec%0d", v));
        end

        // First vector again with input gaps and a 3-cycle result hold.
        load_vec(vt[0]);
        run_txn(3'd0, 64'h5, 64'h5, 4, 0, 0, 3, 3, "stall");

        // Reset mid-stream after two data beats.
        in_valid = 1'b1; mode = 3'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        s_in_valid = 1'b1; s_in = 8'd1;
        @(posedge clk); #1;
        s_in = 8'd2;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("midreset count before", longint'(bus16.count), 2);
        rst = 1'b1;
        #1;
        chk("midreset in_ready", longint'(bus16.in_ready), 1);
        chk("midreset sIn_ready", longint'(bus16.sIn_ready), 0);
        chk("midreset out_valid", longint'(bus16.out_valid), 0);
        chk("midreset sum", longint'(bus16.sum), 0);
        chk("midreset count", longint'(bus16.count), 0);
        chk("midreset ovf", longint'(bus16.ovf), 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        stim_q = '{8'd4, 8'd4};
        run_txn(3'd0, 64'h8, 64'h8, 2, 0, 0, 0, 0, "postreset");

        // Randomized transactions against the model.
        for (int r = 0; r < 40; r++) begin
            logic [2:0] m;
            longint e16, e8;
            bit o16, o8;
            int len;
            m = 3'($urandom_range(0, 7));
            len = $urandom_range(0, 10);
            stim_q.delete();
            for (int k = 0; k < len; k++) stim_q.push_back(8'($urandom_range(0, 255)));
            model(int'(m), 16, e16, o16);
            model(int'(m), 8, e8, o8);
            run_txn(m, e16, e8, longint'(len), o16, o8, $urandom_range(0, 2),
                    $urandom_range(0, 2), $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
